// File: rtl/residue_reducer_seq_if.sv
// rtl/residue_reducer_seq_if.sv - operand/residue valid-ready bundle for residue_reducer_seq
interface residue_reducer_seq_if #(
  parameter int IN_W  = 500,
  parameter int MOD_W = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [MOD_W-1:0] out_residue;

  // Operand source and residue consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_residue
  );

  // Residue engine side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_residue
  );
endinterface

// File: rtl/residue_reducer_seq.sv
// rtl/residue_reducer_seq.sv - sequential MSB-first Horner residue engine (optional RESIDUE_RT_MOD_EN: run-time modulus port mod_in)
module residue_reducer_seq #(
  parameter int IN_W    = 500,
  parameter int MOD     = 2011,
  parameter int MOD_W   = 11,
  parameter int CHUNK_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef RESIDUE_RT_MOD_EN
  input  logic [MOD_W-1:0]       mod_in,
`endif
  residue_reducer_seq_if.slave   bus,
  output logic                   busy
);

  localparam int NCHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W;
  localparam int SR_W   = NCHUNK * CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               load;
  logic               step;
  logic               in_ready_c;
  logic               out_valid_c;
  logic               busy_c;

  logic [SR_W-1:0]    sr_q;
  logic [MOD_W-1:0]   acc_q;
  logic [MOD_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_q;
  logic [CHUNK_W-1:0] chunk;
  logic [MOD_W:0]     mod_x;
  logic               mod_small;

`ifdef RESIDUE_RT_MOD_EN
  logic [MOD_W-1:0]   mod_q;

  // Modulus register: captured with each operand so mod_in may change mid-RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_q <= MOD_W'(MOD);
    end else if (load) begin
      mod_q <= mod_in;
    end
  end

  assign mod_x     = {1'b0, mod_q};
  // A modulus of 0 or 1 has only the residue 0; the datapath result is masked
  assign mod_small = (mod_q < MOD_W'(2));
`else
  localparam logic [MOD_W:0] MOD_X = (MOD_W + 1)'(MOD);

  assign mod_x     = MOD_X;
  assign mod_small = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; DONE can reload in the handshake cycle
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        step   = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign chunk = sr_q[SR_W-1 -: CHUNK_W];

  // One chunk of Horner accumulation as CHUNK_W conditional-subtract bit steps
  always_comb begin
    logic [MOD_W-1:0] a;
    logic [MOD_W:0]   t;
    a = acc_q;
    t = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      t = {a, chunk[CHUNK_W-1-i]};
      if (t >= mod_x) begin
        t = t - mod_x;
      end
      a = t[MOD_W-1:0];
    end
    acc_next = a;
  end

  // Operand shift register, accumulator and chunk counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sr_q  <= SR_W'(bus.in_data);
      acc_q <= '0;
      cnt_q <= CNT_W'(NCHUNK - 1);
    end else if (step) begin
      sr_q  <= sr_q << CHUNK_W;
      acc_q <= acc_next;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_residue = mod_small ? '0 : acc_q;
  assign busy            = busy_c;

endmodule
